fetch_controller: RTL and testbench

- Sequences the instruction ROM. Owns the fetch PC and drives the ROM address and predict-taken input every cycle.
- Captures up to two instructions per cycle into a circular fetch queue and presents up to two per cycle to decode.
- Handles branch-predictor steering, back-pressure stalls, end-of-program halt and redirect flushes from branch resolution.
- Sits between the ROM/BTB and the decode stage.

---
 rtl/fetch_controller_pkg.sv | 23 ++
 rtl/fetch_controller_queue.sv | 59 +++++
 rtl/fetch_controller.sv | 139 +++++++++++++
 tb/tb_fetch_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_controller_pkg.sv
// rtl/fetch_controller_pkg.sv - shared types and defaults for the fetch controller
package fetch_controller_pkg;

  localparam int FQ_DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Default-width queue entry; the controller re-derives it for its own widths.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;
  } fq_entry_t;

  function automatic logic [1:0] slot_count(input logic [1:0] v);
    return {v[1] & v[0], v[0] ^ v[1]};
  endfunction

endpackage

// File: rtl/fetch_controller_queue.sv
// rtl/fetch_controller_queue.sv - 2-in/2-out circular fetch queue with synchronous flush
module fetch_queue
  import fetch_controller_pkg::*;
#(
  parameter int  DEPTH   = FQ_DEPTH_DEFAULT,
  parameter type entry_t = fq_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [1:0]       push_num,
  input  entry_t           push_0,
  input  entry_t           push_1,
  input  logic [1:0]       pop_num,
  output logic [CNT_W-1:0] count,
  output entry_t           head_0,
  output entry_t           head_1
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_1;
  logic [PTR_W-1:0] rd_ptr_1;

  assign wr_ptr_1 = wr_ptr + PTR_ONE;
  assign rd_ptr_1 = rd_ptr + PTR_ONE;
  assign head_0   = mem[rd_ptr];
  assign head_1   = mem[rd_ptr_1];

  // Storage carries no reset; consumers gate it with the occupancy count.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push_num != 2'd0) mem[wr_ptr] <= push_0;
      if (push_num == 2'd2) mem[wr_ptr_1] <= push_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_num);
      rd_ptr <= rd_ptr + PTR_W'(pop_num);
      count  <= count + CNT_W'(push_num) - CNT_W'(pop_num);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch PC sequencing, branch steering and fetch-queue front end
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_PC   = '0,
  parameter int                    FQ_DEPTH   = FQ_DEPTH_DEFAULT,
  localparam int                   CNT_W      = $clog2(FQ_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_predict_taken,
  input  logic [ADDR_WIDTH-1:0] rom_inst_addr_0,
  input  logic [ADDR_WIDTH-1:0] rom_inst_addr_1,
  input  logic [DATA_WIDTH-1:0] rom_inst_0,
  input  logic [DATA_WIDTH-1:0] rom_inst_1,
  input  logic [1:0]            rom_valid,
  input  logic                  bp_taken,
  input  logic [ADDR_WIDTH-1:0] bp_target,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  dec_ready,
  output logic [1:0]            dec_valid,
  output logic [DATA_WIDTH-1:0] dec_inst_0,
  output logic [DATA_WIDTH-1:0] dec_inst_1,
  output logic [ADDR_WIDTH-1:0] dec_pc_0,
  output logic [ADDR_WIDTH-1:0] dec_pc_1,
  output logic                  dec_pred_taken_0,
  output logic                  dec_pred_taken_1,
  output logic [CNT_W-1:0]      fq_count,
  output logic                  halted
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred_taken;
  } entry_t;

  fetch_state_t     state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CNT_W-1:0] free;
  logic             room;
  logic             accept;
  logic             slot_0;
  logic             slot_1;
  logic [1:0]       push_num;
  logic [1:0]       pop_num;
  entry_t           push_0;
  entry_t           push_1;
  entry_t           head_0;
  entry_t           head_1;

  // Occupancy before this cycle's dequeue, so a pop never makes room for a same-cycle fetch.
  assign free   = CNT_W'(FQ_DEPTH) - fq_count;
  assign room   = free >= CNT_W'(2);
  assign accept = (state == RUN) && room && !redirect_valid;

  // Slot 1 is wrong-path whenever slot 0 is predicted taken.
  assign slot_0 = rom_valid[0];
  assign slot_1 = rom_valid[0] & rom_valid[1] & ~bp_taken;

  assign push_num = accept ? slot_count({slot_1, slot_0}) : 2'd0;
  assign pop_num  = (dec_ready && !redirect_valid) ? slot_count(dec_valid) : 2'd0;

  always_comb begin
    push_0            = '0;
    push_0.inst       = rom_inst_0;
    push_0.pc         = rom_inst_addr_0;
    push_0.pred_taken = bp_taken;
    push_1            = '0;
    push_1.inst       = rom_inst_1;
    push_1.pc         = rom_inst_addr_1;
    push_1.pred_taken = 1'b0;
  end

  fetch_queue #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_fetch_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push_num (push_num),
    .push_0   (push_0),
    .push_1   (push_1),
    .pop_num  (pop_num),
    .count    (fq_count),
    .head_0   (head_0),
    .head_1   (head_1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc    <= START_PC;
    end else if (redirect_valid) begin
      state <= RUN;
      pc    <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    end else begin
      case (state)
        RUN: begin
          if (!room) begin
            state <= STALL;
          end else if (slot_0 && bp_taken) begin
            pc <= bp_target;
          end else if (slot_1) begin
            pc <= pc + ADDR_WIDTH'(8);
          end else if (slot_0) begin
            pc    <= pc + ADDR_WIDTH'(4);
            state <= HALT;
          end else begin
            state <= HALT;
          end
        end
        STALL: if (room) state <= RUN;
        HALT:  state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

  assign rom_addr          = pc;
  assign rom_predict_taken = bp_taken;
  assign halted            = (state == HALT);

  assign dec_valid = redirect_valid ? 2'b00
                                    : {fq_count >= CNT_W'(2), fq_count != '0};

  assign dec_inst_0       = dec_valid[0] ? head_0.inst       : '0;
  assign dec_pc_0         = dec_valid[0] ? head_0.pc         : '0;
  assign dec_pred_taken_0 = dec_valid[0] ? head_0.pred_taken : 1'b0;
  assign dec_inst_1       = dec_valid[1] ? head_1.inst       : '0;
  assign dec_pc_1         = dec_valid[1] ? head_1.pc         : '0;
  assign dec_pred_taken_1 = dec_valid[1] ? head_1.pred_taken : 1'b0;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed self-checking bench for fetch_controller
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic        rom_predict_taken;
  logic [31:0] rom_inst_addr_0;
  logic [31:0] rom_inst_addr_1;
  logic [31:0] rom_inst_0;
  logic [31:0] rom_inst_1;
  logic [1:0]  rom_valid;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic [1:0]  dec_valid;
  logic [31:0] dec_inst_0;
  logic [31:0] dec_inst_1;
  logic [31:0] dec_pc_0;
  logic [31:0] dec_pc_1;
  logic        dec_pred_taken_0;
  logic        dec_pred_taken_1;
  logic [3:0]  fq_count;
  logic        halted;

  logic [31:0] prog_end;
  logic        bp_en;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // ROM model: instruction word is 0xA0000000 | address, program occupies [0, prog_end).
  assign bp_taken        = bp_en && (rom_addr == 32'h8);
  assign bp_target       = 32'h40;
  assign rom_inst_addr_0 = rom_addr;
  assign rom_inst_addr_1 = rom_addr + 32'd4;
  assign rom_inst_0      = 32'hA000_0000 | rom_addr;
  assign rom_inst_1      = 32'hA000_0000 | (rom_addr + 32'd4);
  assign rom_valid[0]    = rom_addr < prog_end;
  assign rom_valid[1]    = ((rom_addr + 32'd4) < prog_end) && !bp_taken;

  fetch_controller #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .START_PC   (32'h0),
    .FQ_DEPTH   (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rom_addr          (rom_addr),
    .rom_predict_taken (rom_predict_taken),
    .rom_inst_addr_0   (rom_inst_addr_0),
    .rom_inst_addr_1   (rom_inst_addr_1),
    .rom_inst_0        (rom_inst_0),
    .rom_inst_1        (rom_inst_1),
    .rom_valid         (rom_valid),
    .bp_taken          (bp_taken),
    .bp_target         (bp_target),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .dec_ready         (dec_ready),
    .dec_valid         (dec_valid),
    .dec_inst_0        (dec_inst_0),
    .dec_inst_1        (dec_inst_1),
    .dec_pc_0          (dec_pc_0),
    .dec_pc_1          (dec_pc_1),
    .dec_pred_taken_0  (dec_pred_taken_0),
    .dec_pred_taken_1  (dec_pred_taken_1),
    .fq_count          (fq_count),
    .halted            (halted)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    prog_end       = 32'h18;
    bp_en          = 1'b0;
    #3;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_fq_count", fq_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_dec_inst_0", dec_inst_0, 0);
    step();
    rst_n = 1'b1;

    // Six-instruction program, decode always ready.
    step();
    chk("p6_valid_a", dec_valid, 2'b11);
    chk("p6_pc0_a", dec_pc_0, 32'h0);
    chk("p6_pc1_a", dec_pc_1, 32'h4);
    chk("p6_inst0_a", dec_inst_0, 32'hA000_0000);
    step();
    chk("p6_pc0_b", dec_pc_0, 32'h8);
    chk("p6_pc1_b", dec_pc_1, 32'hC);
    step();
    chk("p6_pc0_c", dec_pc_0, 32'h10);
    chk("p6_pc1_c", dec_pc_1, 32'h14);
    chk("p6_inst1_c", dec_inst_1, 32'hA000_0014);
    chk("p6_addr_c", rom_addr, 32'h18);
    step();
    chk("p6_halted", halted, 1);
    chk("p6_empty", dec_valid, 2'b00);
    chk("p6_addr_hold", rom_addr, 32'h18);

    // Redirect out of HALT back to 0.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    chk("hr_halted", halted, 0);
    chk("hr_addr", rom_addr, 32'h0);

    // Back-pressure fill to full queue.
    prog_end  = 32'h100;
    dec_ready = 1'b0;
    step();
    chk("bp_cnt2", fq_count, 2);
    chk("bp_addr8", rom_addr, 32'h8);
    step();
    step();
    step();
    chk("full_cnt", fq_count, 8);
    chk("full_addr", rom_addr, 32'h20);
    step();
    chk("stall_addr", rom_addr, 32'h20);
    chk("stall_cnt", fq_count, 8);
    dec_ready = 1'b1;
    chk("stall_dvalid", dec_valid, 2'b11);
    step();
    dec_ready = 1'b0;
    chk("pop_cnt6", fq_count, 6);
    chk("pop_addr_hold", rom_addr, 32'h20);
    step();
    chk("resume_addr_hold", rom_addr, 32'h20);
    chk("resume_cnt", fq_count, 6);
    step();
    chk("resume_addr", rom_addr, 32'h28);
    chk("resume_cnt8", fq_count, 8);
    chk("resume_head", dec_pc_0, 32'h8);

    // Redirect with a full queue.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    #1;
    chk("redir_full_dvalid", dec_valid, 2'b00);
    step();
    redirect_valid = 1'b0;
    chk("redir_full_cnt", fq_count, 0);

    // Predicted-taken branch at 0x8.
    bp_en = 1'b1;
    step();
    chk("bt_addr8", rom_addr, 32'h8);
    chk("bt_predict", rom_predict_taken, 1);
    step();
    chk("bt_target", rom_addr, 32'h40);
    chk("bt_cnt3", fq_count, 3);
    dec_ready = 1'b1;
    step();
    dec_ready = 1'b0;
    chk("bt_head_pc", dec_pc_0, 32'h8);
    chk("bt_head_pred", dec_pred_taken_0, 1);
    chk("bt_next_pc", dec_pc_1, 32'h40);
    chk("bt_next_pred", dec_pred_taken_1, 0);
    chk("bt_cnt3b", fq_count, 3);
    step();
    chk("rd_cnt5", fq_count, 5);

    // Redirect to an unaligned target while five entries are queued.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    chk("rd_dvalid0", dec_valid, 2'b00);
    step();
    redirect_valid = 1'b0;
    chk("rd_cnt0", fq_count, 0);
    chk("rd_addr", rom_addr, 32'h100);
    step();
    chk("rd_halt_oob", halted, 1);

    // Three-instruction program: last fetch has only slot 0 valid.
    bp_en          = 1'b0;
    prog_end       = 32'hC;
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    step();
    chk("odd_addr8", rom_addr, 32'h8);
    chk("odd_pair", dec_pc_1, 32'h4);
    step();
    chk("odd_halted", halted, 1);
    chk("odd_cnt1", fq_count, 1);
    chk("odd_dvalid", dec_valid, 2'b01);
    chk("odd_pc0", dec_pc_0, 32'h8);
    chk("odd_addr_c", rom_addr, 32'hC);

    // Mid-stream asynchronous reset.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    step();
    chk("pre_rst_cnt", fq_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cnt", fq_count, 0);
    chk("arst_dvalid", dec_valid, 0);
    chk("arst_addr", rom_addr, 0);
    chk("arst_inst", dec_inst_0, 0);
    chk("arst_halted", halted, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("restart_addr", rom_addr, 32'h8);
    chk("restart_pc1", dec_pc_1, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
